// File: rtl/fetch_predict_stage_pkg.sv
// Shared types and constants for the fetch/predict stage and its branch target buffer.
package fetch_predict_stage_pkg;

    typedef logic [31:0] instruction_type;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic        hit;
    } branch_predict_type;

    localparam instruction_type NOP_INSTR = 32'h0000_0013;

    // 2-bit saturating counter step towards the resolved direction.
    function automatic logic [1:0] counter_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'd1;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/fetch_predict_stage_if.sv
// Control, training, instruction-memory and IF/ID signals of the fetch stage.
interface fetch_predict_stage_if;
    import fetch_predict_stage_pkg::*;

    logic               stall;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               update_valid;
    logic [31:0]        update_pc;
    logic               update_taken;
    logic [31:0]        update_target;
    logic [31:0]        imem_addr;
    logic [31:0]        imem_rdata;
    instruction_type    instruction_out;
    logic [31:0]        pc_out;
    branch_predict_type branch_out;
    logic               valid_out;

    modport master (
        input  stall, redirect_valid, redirect_pc, update_valid, update_pc, update_taken,
               update_target, imem_rdata,
        output imem_addr, instruction_out, pc_out, branch_out, valid_out
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, update_valid, update_pc, update_taken,
               update_target, imem_rdata,
        input  imem_addr, instruction_out, pc_out, branch_out, valid_out
    );

endinterface

// File: rtl/fetch_predict_stage_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
module fetch_predict_stage_btb
    import fetch_predict_stage_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES  = 16,
    parameter logic [1:0]  COUNTER_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] lookup_pc,
    output logic        lookup_hit,
    output logic        lookup_taken,
    output logic [31:0] lookup_target,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target
);
    localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [31:0]            target_q [BTB_ENTRIES];
    logic [1:0]             ctr_q    [BTB_ENTRIES];

    logic [IDX-1:0]   lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             up_hit;
    logic             unused_pc_lsbs;

    assign lk_idx         = lookup_pc[IDX+1:2];
    assign lk_tag         = lookup_pc[31:IDX+2];
    assign up_idx         = update_pc[IDX+1:2];
    assign up_tag         = update_pc[31:IDX+2];
    assign unused_pc_lsbs = ^{lookup_pc[1:0], update_pc[1:0]};

    assign lookup_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lookup_taken  = lookup_hit && ctr_q[lk_idx][1];
    assign lookup_target = target_q[lk_idx];
    assign up_hit        = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Lookup is combinational on current contents, so a same-cycle update is seen next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= COUNTER_INIT;
            end
        end else if (update_valid) begin
            if (up_hit) begin
                ctr_q[up_idx] <= counter_next(ctr_q[up_idx], update_taken);
                if (update_taken) begin
                    target_q[up_idx] <= update_target;
                end
            end else if (update_taken) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= update_target;
                ctr_q[up_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: rtl/fetch_predict_stage.sv
// IF stage: PC register, BTB-predicted next-PC selection and the IF/ID pipeline register.
module fetch_predict_stage
    import fetch_predict_stage_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES  = 16,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [1:0]  COUNTER_INIT = 2'b01
) (
    input logic                   clk,
    input logic                   reset,
    fetch_predict_stage_if.master bus
);
    logic [31:0]        pc_q, pc_d, pc_plus4;
    logic               pred_hit, pred_taken;
    logic [31:0]        entry_target, pred_target;
    instruction_type    instr_q;
    logic [31:0]        pc_out_q;
    branch_predict_type branch_q;
    logic               valid_q;
    logic               unused_redirect_lsbs;

    fetch_predict_stage_btb #(
        .BTB_ENTRIES  (BTB_ENTRIES),
        .COUNTER_INIT (COUNTER_INIT)
    ) u_btb (
        .clk           (clk),
        .reset         (reset),
        .lookup_pc     (pc_q),
        .lookup_hit    (pred_hit),
        .lookup_taken  (pred_taken),
        .lookup_target (entry_target),
        .update_valid  (bus.update_valid),
        .update_pc     (bus.update_pc),
        .update_taken  (bus.update_taken),
        .update_target (bus.update_target)
    );

    assign pc_plus4             = pc_q + 32'd4;
    assign pred_target          = pred_hit ? entry_target : pc_plus4;
    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    always_comb begin
        pc_d = pred_taken ? entry_target : pc_plus4;
        if (bus.redirect_valid) begin
            pc_d = {bus.redirect_pc[31:2], 2'b00};
        end else if (bus.stall) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // A redirect squashes the fetched word even while the hazard unit is stalling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q  <= NOP_INSTR;
            pc_out_q <= '0;
            branch_q <= '0;
            valid_q  <= 1'b0;
        end else if (bus.redirect_valid) begin
            instr_q  <= NOP_INSTR;
            pc_out_q <= '0;
            branch_q <= '0;
            valid_q  <= 1'b0;
        end else if (!bus.stall) begin
            instr_q  <= bus.imem_rdata;
            pc_out_q <= pc_q;
            branch_q <= '{taken: pred_taken, target: pred_target, hit: pred_hit};
            valid_q  <= 1'b1;
        end
    end

    assign bus.imem_addr       = pc_q;
    assign bus.instruction_out = instr_q;
    assign bus.pc_out          = pc_out_q;
    assign bus.branch_out      = branch_q;
    assign bus.valid_out       = valid_q;

endmodule

// File: tb/tb_fetch_predict_stage.sv
// Directed bench for fetch_predict_stage against a per-cycle behavioural model.
module tb_fetch_predict_stage;
    import fetch_predict_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_en = 0;

    fetch_predict_stage_if bus ();

    fetch_predict_stage #(
        .BTB_ENTRIES  (16),
        .RESET_PC     (RST_PC),
        .COUNTER_INIT (2'b01)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign bus.imem_rdata = imem_word(bus.imem_addr);

    // Model: architectural PC, IF/ID contents and a 16-entry table keyed by pc[5:2].
    logic [31:0] m_pc, m_instr, m_pcout;
    logic [33:0] m_br;
    logic        m_vo;
    bit          m_bv   [16];
    logic [31:0] m_bpc  [16];
    logic [31:0] m_btgt [16];
    int          m_ctr  [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pc = RST_PC; m_instr = 32'h0000_0013; m_pcout = '0; m_br = '0; m_vo = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_bv[i] = 0; m_bpc[i] = '0; m_btgt[i] = '0; m_ctr[i] = 1;
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_addr", bus.imem_addr, m_pc);
            chk("instruction_out", bus.instruction_out, m_instr);
            chk("pc_out", bus.pc_out, m_pcout);
            chk("branch_out", bus.branch_out, m_br);
            chk("valid_out", bus.valid_out, m_vo);
        end
    end

    // Advance one clock; the model computes its next state from the inputs now applied.
    task automatic step();
        int          s, u;
        bit          h, tk, uh, utk, uv;
        logic [31:0] tg, npc, ni, npo, upc, utg;
        logic [33:0] nbr;
        logic        nv;
        s   = int'(m_pc[5:2]);
        h   = m_bv[s] && (m_bpc[s][31:6] == m_pc[31:6]);
        tk  = h && (m_ctr[s] >= 2);
        tg  = h ? m_btgt[s] : m_pc + 32'd4;
        npc = m_pc; ni = m_instr; npo = m_pcout; nbr = m_br; nv = m_vo;
        if (bus.redirect_valid) begin
            npc = {bus.redirect_pc[31:2], 2'b00};
            ni = 32'h0000_0013; npo = '0; nbr = '0; nv = 1'b0;
        end else if (!bus.stall) begin
            npc = tk ? m_btgt[s] : m_pc + 32'd4;
            ni = imem_word(m_pc); npo = m_pc; nbr = {tk, tg, h}; nv = 1'b1;
        end
        uv = bus.update_valid; upc = bus.update_pc; utk = bus.update_taken;
        utg = bus.update_target;
        @(posedge clk);
        #1;
        m_pc = npc; m_instr = ni; m_pcout = npo; m_br = nbr; m_vo = nv;
        if (uv) begin
            u  = int'(upc[5:2]);
            uh = m_bv[u] && (m_bpc[u][31:6] == upc[31:6]);
            if (uh) begin
                m_ctr[u] = utk ? ((m_ctr[u] == 3) ? 3 : m_ctr[u] + 1)
                               : ((m_ctr[u] == 0) ? 0 : m_ctr[u] - 1);
                if (utk) m_btgt[u] = utg;
            end else if (utk) begin
                m_bv[u] = 1; m_bpc[u] = upc; m_btgt[u] = utg; m_ctr[u] = 2;
            end
        end
    endtask

    task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        bus.update_valid = 1'b1; bus.update_pc = pc;
        bus.update_taken = taken; bus.update_target = tgt;
        step();
        bus.update_valid = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        bus.redirect_valid = 1'b1; bus.redirect_pc = pc;
        step();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = '0;
        bus.update_valid = 0; bus.update_pc = '0; bus.update_taken = 0; bus.update_target = '0;
        reset = 1'b1;
        model_reset();
        #12;
        reset = 1'b0;
        chk("rst imem_addr", bus.imem_addr, 32'h100);
        chk("rst valid_out", bus.valid_out, 1'b0);
        chk("rst instruction", bus.instruction_out, 32'h13);
        chk("rst pc_out", bus.pc_out, 32'h0);
        chk("rst branch_out", bus.branch_out, 34'h0);
        chk_en = 1;

        // Free-running fetch; training 108 in flight does not affect the current lookup
        step();
        chk("free imem_addr", bus.imem_addr, 32'h104);
        chk("free pc_out", bus.pc_out, 32'h100);
        chk("free valid_out", bus.valid_out, 1'b1);
        chk("free hit", bus.branch_out.hit, 1'b0);
        train(32'h108, 1'b1, 32'h200);
        chk("alloc imem_addr", bus.imem_addr, 32'h108);
        step();
        chk("pred imem_addr", bus.imem_addr, 32'h200);
        chk("pred branch_out", bus.branch_out, {1'b1, 32'h200, 1'b1});

        // Counter walks down, saturates at 0, climbs and saturates at 3
        train(32'h108, 1'b0, 32'h0);
        train(32'h108, 1'b0, 32'h0);
        redirect(32'h108);
        step();
        chk("ctr0 imem_addr", bus.imem_addr, 32'h10C);
        chk("ctr0 branch_out", bus.branch_out, {1'b0, 32'h200, 1'b1});
        train(32'h108, 1'b0, 32'h0);
        train(32'h108, 1'b1, 32'h300);
        redirect(32'h108);
        step();
        chk("ctr1 imem_addr", bus.imem_addr, 32'h10C);
        chk("ctr1 branch_out", bus.branch_out, {1'b0, 32'h300, 1'b1});
        for (int i = 0; i < 3; i++) train(32'h108, 1'b1, 32'h300);
        train(32'h108, 1'b0, 32'h0);
        redirect(32'h108);
        step();
        chk("ctr2 imem_addr", bus.imem_addr, 32'h300);

        // Redirect during a stall wins and its bubble is held
        bus.stall = 1'b1;
        step();
        redirect(32'h403);
        step();
        chk("stall imem_addr", bus.imem_addr, 32'h400);
        chk("stall valid_out", bus.valid_out, 1'b0);
        chk("stall instruction", bus.instruction_out, 32'h13);
        bus.stall = 1'b0;
        step();
        chk("unstall pc_out", bus.pc_out, 32'h400);

        // Same-cycle update and lookup on index 2: old counter (2) decides
        redirect(32'h108);
        train(32'h108, 1'b0, 32'h0);
        chk("same-cycle imem_addr", bus.imem_addr, 32'h300);
        redirect(32'h108);
        step();
        chk("after-update imem_addr", bus.imem_addr, 32'h10C);

        // Mid-stream reset clears the pipeline and BTB immediately
        chk_en = 0;
        reset = 1'b1;
        #1;
        chk("mid rst imem_addr", bus.imem_addr, 32'h100);
        chk("mid rst valid_out", bus.valid_out, 1'b0);
        chk("mid rst instruction", bus.instruction_out, 32'h13);
        chk("mid rst branch_out", bus.branch_out, 34'h0);
        #2;
        reset = 1'b0;
        model_reset();
        chk_en = 1;
        redirect(32'h108);
        step();
        chk("btb cleared hit", bus.branch_out.hit, 1'b0);
        chk("btb cleared imem_addr", bus.imem_addr, 32'h10C);
        redirect(32'hFFFF_FFFC);
        step();
        chk("wrap imem_addr", bus.imem_addr, 32'h0);
        step();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
